router_fifo_pkt_p: RTL and testbench

ROUTER_FIFO_PKT_P -- requirements
Module: router_fifo_pkt_p

---
 rtl/router_fifo_pkt_p_if.sv | 42 ++++
 rtl/router_fifo_pkt_p.sv | 115 +++++++++++
 tb/tb_router_fifo_pkt_p.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_fifo_pkt_p_if.sv
// Bus bundle for the packet FIFO: write port, read port, status flags
// and the read-side packet counter exposed for observation.
//
// Handshake: a write is taken on a rising edge when wr_en && !full, and a
// read is taken when rd_en && !empty. Each decision looks only at its own
// port. The word that was read appears on data_out/hdr_out one cycle after
// it is taken. A request that is refused produces a one-cycle ovf or udf
// pulse, also one cycle later.
interface router_fifo_pkt_p_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = (DATA_W - 1 > 8) ? DATA_W - 1 : 8;

    logic              wr_en;
    logic              lfd_state;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic [DATA_W-1:0] data_out;
    logic              hdr_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [LVL_W-1:0]  fill_level;
    logic              pkt_done;
    logic              ovf;
    logic              udf;
    logic [CNT_W-1:0]  pkt_cnt;

    modport master (
        output wr_en, lfd_state, data_in, rd_en,
        input  data_out, hdr_out, full, empty, almost_full, fill_level,
               pkt_done, ovf, udf, pkt_cnt
    );

    modport slave (
        input  wr_en, lfd_state, data_in, rd_en,
        output data_out, hdr_out, full, empty, almost_full, fill_level,
               pkt_done, ovf, udf, pkt_cnt
    );
endinterface

// File: rtl/router_fifo_pkt_p.sv
// Packet-aware synchronous FIFO. Each entry stores a header flag together
// with a data word. On the read side a counter follows the packet length
// carried in each header, and pkt_done pulses with the packet's last word.
module router_fifo_pkt_p #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2
) (
    input logic               clk,
    input logic               rst,
    input logic               soft_rst,
    router_fifo_pkt_p_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int CNT_W = (DATA_W - 1 > 8) ? DATA_W - 1 : 8;

    logic [DATA_W:0]   mem [DEPTH];
    logic [PW-1:0]     wp;
    logic [PW-1:0]     rp;
    logic [PW-1:0]     level;
    logic [DATA_W-1:0] dout_q;
    logic              hdr_q;
    logic              done_q;
    logic              ovf_q;
    logic              udf_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              is_full;
    logic              is_empty;
    logic              wr_ok;
    logic              rd_ok;
    logic [DATA_W:0]   rd_word;
    logic [CNT_W-1:0]  hdr_len;

    // The flags come only from the registered pointers. The extra top bit
    // tells a full FIFO apart from an empty one when the addresses match.
    assign is_empty = (wp == rp);
    assign is_full  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
    assign level    = wp - rp;
    assign wr_ok    = bus.wr_en && !is_full;
    assign rd_ok    = bus.rd_en && !is_empty;
    assign rd_word  = mem[rp[AW-1:0]];
    // A header's upper bits give the payload length. Adding one counts the
    // parity word that ends the packet.
    assign hdr_len  = CNT_W'(rd_word[DATA_W-1:2]) + CNT_W'(1);

    assign bus.data_out    = dout_q;
    assign bus.hdr_out     = hdr_q;
    assign bus.full        = is_full;
    assign bus.empty       = is_empty;
    assign bus.fill_level  = level;
    assign bus.almost_full = (level >= PW'(AF_THRESH));
    assign bus.pkt_done    = done_q;
    assign bus.ovf         = ovf_q;
    assign bus.udf         = udf_q;
    assign bus.pkt_cnt     = cnt_q;

    // Storage array: written only on accepted writes. A flush leaves the
    // contents in place.
    always_ff @(posedge clk) begin
        if (wr_ok && !soft_rst) begin
            mem[wp[AW-1:0]] <= {bus.lfd_state, bus.data_in};
        end
    end

    // Write pointer: advances on each accepted write, cleared by either reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
        end else if (soft_rst) begin
            wp <= '0;
        end else if (wr_ok) begin
            wp <= wp + PW'(1);
        end
    end

    // Read side: read pointer, registered output word, packet counter and
    // the one-cycle event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp     <= '0;
            dout_q <= '0;
            hdr_q  <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (soft_rst) begin
            rp     <= '0;
            dout_q <= '0;
            hdr_q  <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            ovf_q  <= bus.wr_en && is_full;
            udf_q  <= bus.rd_en && is_empty;
            done_q <= 1'b0;
            if (rd_ok) begin
                rp     <= rp + PW'(1);
                dout_q <= rd_word[DATA_W-1:0];
                hdr_q  <= rd_word[DATA_W];
                if (rd_word[DATA_W]) begin
                    // A new header restarts the count. Any unfinished
                    // packet is dropped without a pkt_done.
                    cnt_q <= hdr_len;
                end else if (cnt_q != '0) begin
                    cnt_q  <= cnt_q - CNT_W'(1);
                    done_q <= (cnt_q == CNT_W'(1));
                end
            end
        end
    end
endmodule

// File: tb/tb_router_fifo_pkt_p.sv
// Bench for router_fifo_pkt_p. A queue-based model predicts the stored
// words, the status flags, the output word and the packet-length
// bookkeeping. Random traffic is then compared against it cycle by cycle.
module tb_router_fifo_pkt_p;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 16;
    localparam int AF_THRESH = DEPTH - 2;
    localparam int W         = DATA_W + 1;
    localparam int LVL_W     = $clog2(DEPTH) + 1;
    localparam int CNT_W     = 8;
    localparam int VW        = DATA_W + 7 + LVL_W + CNT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic soft_rst = 1'b0;

    router_fifo_pkt_p_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    router_fifo_pkt_p #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)
    ) dut (
        .clk(clk), .rst(rst), .soft_rst(soft_rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // Model state: the words stored in the FIFO, the expected output
    // registers and the number of words left in the current packet.
    logic [W-1:0]      exp_q[$];
    logic [DATA_W-1:0] exp_dout;
    logic              exp_hdr;
    logic              exp_done;
    logic              exp_ovf;
    logic              exp_udf;
    int                rem;
    int                n_checks = 0;
    int                n_fail = 0;

    function automatic logic [VW-1:0] obs_vec();
        return {bus.data_out, bus.hdr_out, bus.pkt_done, bus.ovf, bus.udf,
                bus.full, bus.empty, bus.almost_full, bus.fill_level, bus.pkt_cnt};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        int sz = exp_q.size();
        return {exp_dout, exp_hdr, exp_done, exp_ovf, exp_udf,
                (sz == DEPTH), (sz == 0), (sz >= AF_THRESH),
                LVL_W'(sz), CNT_W'(rem)};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_dout = '0;
        exp_hdr  = 1'b0;
        exp_done = 1'b0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
        rem      = 0;
    endtask

    // Applies one cycle of stimulus, updates the model, and returns 1 time
    // unit after the rising edge with the inputs back at idle.
    task automatic drive(input logic wr, input logic hdr, input logic [DATA_W-1:0] din,
                         input logic rd, input logic srst);
        int sz = exp_q.size();
        logic [W-1:0] w;
        bus.wr_en     = wr;
        bus.lfd_state = hdr;
        bus.data_in   = din;
        bus.rd_en     = rd;
        soft_rst      = srst;
        if (srst) begin
            model_reset();
        end else begin
            exp_ovf  = wr && (sz == DEPTH);
            exp_udf  = rd && (sz == 0);
            exp_done = 1'b0;
            if (rd && sz != 0) begin
                w = exp_q.pop_front();
                exp_dout = w[DATA_W-1:0];
                exp_hdr  = w[DATA_W];
                if (w[DATA_W]) begin
                    rem = int'(w[DATA_W-1:2]) + 1;
                end else if (rem > 0) begin
                    rem--;
                    exp_done = (rem == 0);
                end
            end
            if (wr && sz != DEPTH) exp_q.push_back({hdr, din});
        end
        @(posedge clk);
        #1;
        bus.wr_en     = 1'b0;
        bus.lfd_state = 1'b0;
        bus.data_in   = '0;
        bus.rd_en     = 1'b0;
        soft_rst      = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] pay;
        rst = 1'b1;
        model_reset();
        #3;
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), exp_vec());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b1, 8'h0C, 1'b0, 1'b0);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_hdr_write: got %h expected %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            pay = DATA_W'($urandom_range(0, 255));
            drive(1'b1, 1'b0, pay, 1'b0, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_pay_write[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_pkt_read[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(1'b1, 1'b0, DATA_W'($urandom_range(0, 255)), 1'b0, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL full_write[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, DATA_W'($urandom_range(0, 255)), 1'b0, 1'b0);
        drive(1'b1, 1'b0, DATA_W'($urandom_range(0, 255)), 1'b1, 1'b0);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL simul_level5: got %h expected %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < DEPTH - 5; i++) drive(1'b1, 1'b0, DATA_W'($urandom_range(0, 255)), 1'b0, 1'b0);
        drive(1'b1, 1'b0, DATA_W'($urandom_range(0, 255)), 1'b1, 1'b0);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL simul_full: got %h expected %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL simul_drain[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, DATA_W'($urandom_range(0, 255)), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, ($urandom_range(0, 3) == 0), DATA_W'($urandom_range(0, 255)), 1'b1, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 55), ($urandom_range(0, 3) == 0),
                  DATA_W'($urandom_range(0, 255)), ($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 59) == 0));
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_soft_rst();
        pulse_rst();
        drive(1'b1, 1'b1, 8'h20, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, DATA_W'($urandom_range(0, 255)) | 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL soft_pre_level7: got %h expected %h", obs_vec(), exp_vec());
        end
        drive(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL soft_flush: got %h expected %h", obs_vec(), exp_vec());
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL soft_udf: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_async_rst();
        drive(1'b1, 1'b1, 8'h30, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, DATA_W'($urandom_range(0, 255)) | 8'h01, 1'b0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_pre_level9: got %h expected %h", obs_vec(), exp_vec());
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_rst_midcycle: got %h expected %h", obs_vec(), exp_vec());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_post_write: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        bus.wr_en     = 1'b0;
        bus.lfd_state = 1'b0;
        bus.data_in   = '0;
        bus.rd_en     = 1'b0;
        model_reset();
        test_reset();
        test_full();
        test_simultaneous();
        test_wrap();
        test_random();
        test_soft_rst();
        test_async_rst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
